// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial datapath stages: the control FSM
// state encoding and the default operand width. Later serial stages import
// this package so that they all decode the same state values.
package serial_adder_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// fa
// Existing 1-bit full adder cell, purely combinational.
// Ports: cout - carry out, sum - sum bit, a/b - operand bits, cin - carry in.
module fa (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial W-bit adder. One operand bit pair is fed to the fa cell per
// clock, LSB first; the carry is registered between bits and the produced
// sum bits are shifted into the result register from the top.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - launch request, honoured only in IDLE
//   a, b  - W-bit operands, captured on the accepted start edge
//   cin   - carry-in, captured on the accepted start edge
//   busy  - high while bits are being processed
//   done  - one-cycle pulse, sum/cout valid
//   sum   - (a + b + cin) mod 2^W, held until the next accepted start
//   cout  - carry out of bit W-1, held until the next accepted start
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic           c;
  logic [CW-1:0]  cnt;
  logic           fa_sum;
  logic           fa_cout;

  fa u_fa (
    .cout (fa_cout),
    .sum  (fa_sum),
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter is cleared on every accepted start, so letting it wrap after
  // the last bit (power-of-two W) is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra   <= a;
            rb   <= b;
            c    <= cin;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
          end
        end
        ADD: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          sum <= {fa_sum, sum[W-1:1]};
          c   <= fa_cout;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) cout <= fa_cout;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule
